out_reg_write_seq: RTL and testbench

- Write sequencer directly upstream of the 16-channel output register bank.
- Accepts host write commands (4-bit channel address plus 8-bit data) into a small command FIFO.
- Replays each command to the bank as a shared 8-bit data bus plus a one-hot select strobe.
- Data is guaranteed stable for programmable setup and hold windows around the select rising edge, which is the bank's register clock.

---
 rtl/out_reg_write_seq_pkg.sv | 33 +++
 rtl/out_reg_write_seq_cmd_fifo.sv | 62 ++++++
 rtl/out_reg_write_seq.sv | 169 ++++++++++++++++
 tb/tb_out_reg_write_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_reg_write_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : out_reg_pkg
//  Purpose    : Shared widths, the host write-command record and the write
//               sequencer state type for the output register bank front end.
//  Contents   : NUM_CH, CH_AW, DW, wr_cmd_t, seq_state_t, ch_onehot()
//  Revision   : 1.0  initial release
// ============================================================================
package out_reg_pkg;

  localparam int NUM_CH = 16;  // output register channels in the bank
  localparam int CH_AW  = 4;   // channel address width
  localparam int DW     = 8;   // data bus width

  typedef struct packed {
    logic [CH_AW-1:0] addr;
    logic [DW-1:0]    data;
  } wr_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

  // Channel address to one-hot select vector.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_AW-1:0] a);
    return NUM_CH'(1) << a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/out_reg_write_seq_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : cmd_fifo
//  Purpose    : Synchronous FIFO of wr_cmd_t holding host write commands
//               until the sequencer replays them to the register bank.
//  Ports      : CLK   - clock, rising edge
//               CLR   - asynchronous active-high reset (empties the FIFO)
//               push  - write din (ignored when full)
//               pop   - discard head entry (ignored when empty)
//               din   - command to store
//               dout  - head entry (valid when !empty)
//               full  - no free entry
//               empty - no stored entry
//  Revision   : 1.0  initial release
// ============================================================================
module cmd_fifo
  import out_reg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    CLK,
  input  logic    CLR,
  input  logic    push,
  input  logic    pop,
  input  wr_cmd_t din,
  output wr_cmd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  wr_cmd_t      r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;   // extra MSB distinguishes full from empty
  logic [AW:0]  r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/out_reg_write_seq.sv
`default_nettype none
// ============================================================================
//  Module     : out_reg_write_seq
//  Purpose    : Write sequencer in front of the 16-channel output register
//               bank. Host commands are queued, then replayed as a shared
//               data bus plus one-hot select strobe with programmable setup,
//               strobe and hold windows around the select rising edge.
//  Ports      : CLK      - clock, rising edge
//               CLR      - asynchronous active-high reset
//               wr_req   - host write request
//               wr_addr  - target channel 0..15
//               wr_data  - data for the channel
//               wr_ready - FIFO can accept (write = wr_req && wr_ready)
//               ovf_clr  - synchronous clear of ovf
//               ovf      - sticky: request seen while wr_ready low
//               data_out - shared data bus to the bank
//               sel      - one-hot select strobes to the bank
//               busy     - sequencer active or commands queued
//  Revision   : 1.0  initial release
// ============================================================================
module out_reg_write_seq
  import out_reg_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              wr_req,
  input  logic [CH_AW-1:0]  wr_addr,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_ready,
  input  logic              ovf_clr,
  output logic              ovf,
  output logic [DW-1:0]     data_out,
  output logic [NUM_CH-1:0] sel,
  output logic              busy
);

  localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES)
                      ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                      : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] C_SETUP  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_STROBE = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_CYCLES - 1);

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [CH_AW-1:0]   r_addr;
  logic [DW-1:0]      r_data_out;
  logic [NUM_CH-1:0]  r_sel;
  logic               r_ovf;

  wr_cmd_t            w_din;
  wr_cmd_t            w_dout;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;

  assign w_din.addr = wr_addr;
  assign w_din.data = wr_data;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .CLK   (CLK),
    .CLR   (CLR),
    .push  (wr_req),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Next-state / pop decision. The counter is reloaded on every state entry
  // and decremented otherwise; a state is left when it reads zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SETUP;
          w_cnt_nxt   = C_SETUP;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = STROBE;
          w_cnt_nxt   = C_STROBE;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      STROBE: begin
        if (r_cnt == '0) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = C_HOLD;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          // Chain straight into the next command without an IDLE bubble.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = SETUP;
            w_cnt_nxt   = C_SETUP;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // data_out/addr load only on a pop (entry to SETUP); sel follows STROBE
  // occupancy. Since SETUP and HOLD each last at least one cycle, the two
  // never move on the same edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data_out <= '0;
      r_sel      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_pop) begin
        r_addr     <= w_dout.addr;
        r_data_out <= w_dout.data;
      end
      r_sel <= (w_state_nxt == STROBE) ? ch_onehot(r_addr) : '0;
      // A refused request outranks a simultaneous clear.
      if (wr_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign wr_ready = !w_full;
  assign busy     = (r_state != IDLE) || !w_empty;
  assign ovf      = r_ovf;
  assign data_out = r_data_out;
  assign sel      = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_out_reg_write_seq.sv
`default_nettype none
// ============================================================================
//  Module     : tb_out_reg_write_seq
//  Purpose    : Self-checking bench for out_reg_write_seq. Two instances run
//               side by side (default timing and 2/3/2 timing) against a
//               queue-based reference model of the write sequencer.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_out_reg_write_seq;
  import out_reg_pkg::*;

  localparam int NI    = 2;
  localparam int DEPTH = 4;
  localparam int PS [NI] = '{1, 2};
  localparam int PT [NI] = '{1, 3};
  localparam int PH [NI] = '{1, 2};

  logic        CLK = 1'b0;
  logic        CLR;
  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        ovf_clr;

  logic [NI-1:0] o_rdy;
  logic [NI-1:0] o_ovf;
  logic [NI-1:0] o_busy;
  logic [7:0]    o_dout [NI];
  logic [15:0]   o_sel  [NI];

  always #5 CLK = ~CLK;

  out_reg_write_seq u_dut0 (
    .CLK(CLK), .CLR(CLR), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(o_rdy[0]), .ovf_clr(ovf_clr), .ovf(o_ovf[0]),
    .data_out(o_dout[0]), .sel(o_sel[0]), .busy(o_busy[0])
  );

  out_reg_write_seq #(
    .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)
  ) u_dut1 (
    .CLK(CLK), .CLR(CLR), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(o_rdy[1]), .ovf_clr(ovf_clr), .ovf(o_ovf[1]),
    .data_out(o_dout[1]), .sel(o_sel[1]), .busy(o_busy[1])
  );

  // ---------------- reference model ----------------
  // m_cnt: cycles left in the current command's setup+strobe+hold window.
  wr_cmd_t     mq [NI][$];
  int          m_cnt  [NI];
  logic [3:0]  m_addr [NI];
  logic [7:0]  m_data [NI];
  logic        m_ovf  [NI];
  logic [15:0] p_sel  [NI];
  logic [7:0]  p_dout [NI];

  int nrun  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nrun++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_sel(input int k);
    int e;
    e = PS[k] + PT[k] + PH[k] - m_cnt[k];
    if (m_cnt[k] > 0 && e >= PS[k] && e < PS[k] + PT[k])
      return 16'(1) << m_addr[k];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      m_cnt[k]  = 0;
      m_addr[k] = '0;
      m_data[k] = '0;
      m_ovf[k]  = 1'b0;
      p_sel[k]  = '0;
      p_dout[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      bit      full_pre;
      bit      can_pop;
      wr_cmd_t c;
      full_pre = (mq[k].size() == DEPTH);
      can_pop  = (m_cnt[k] <= 1) && (mq[k].size() > 0);
      if (wr_req && full_pre) m_ovf[k] = 1'b1;
      else if (ovf_clr)       m_ovf[k] = 1'b0;
      if (can_pop) begin
        c = mq[k].pop_front();
        m_addr[k] = c.addr;
        m_data[k] = c.data;
        m_cnt[k]  = PS[k] + PT[k] + PH[k];
      end else if (m_cnt[k] > 0) begin
        m_cnt[k]--;
      end
      if (wr_req && !full_pre) begin
        c.addr = wr_addr;
        c.data = wr_data;
        mq[k].push_back(c);
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("sel[%0d]", k),      o_sel[k],  exp_sel(k));
      chk($sformatf("data_out[%0d]", k), o_dout[k], m_data[k]);
      chk($sformatf("busy[%0d]", k),     o_busy[k], (m_cnt[k] > 0) || (mq[k].size() > 0));
      chk($sformatf("wr_ready[%0d]", k), o_rdy[k],  mq[k].size() < DEPTH);
      chk($sformatf("ovf[%0d]", k),      o_ovf[k],  m_ovf[k]);
      chk($sformatf("onehot0[%0d]", k),  $onehot0(o_sel[k]), 1);
      chk($sformatf("sel_data_same_edge[%0d]", k),
          (o_sel[k] != p_sel[k]) && (o_dout[k] != p_dout[k]), 0);
      p_sel[k]  = o_sel[k];
      p_dout[k] = o_dout[k];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic drive(input logic req, input logic [3:0] a, input logic [7:0] d);
    wr_req  = req;
    wr_addr = a;
    wr_data = d;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int  hits;
    bit  found;
    CLR = 1'b1;
    drive(1'b0, 4'h0, 8'h00);
    ovf_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    check_all();
    CLR = 1'b0;

    // Single write, addr 5 / 0xA5.
    drive(1'b1, 4'd5, 8'hA5);
    step();                                   // edge E: accepted
    drive(1'b0, 4'd0, 8'h00);
    step();                                   // E+1
    chk("single_data_E1", o_dout[0], 8'hA5);
    step();                                   // E+2
    chk("single_sel_E2", o_sel[0], 16'h0020);
    step();                                   // E+3
    chk("single_sel_E3", o_sel[0], 16'h0000);
    repeat (10) step();
    chk("single_busy_done", o_busy[0], 0);
    chk("single_data_retained", o_dout[0], 8'hA5);

    // Back-to-back writes.
    drive(1'b1, 4'd0,  8'h11); step();
    drive(1'b1, 4'd15, 8'hFF); step();
    drive(1'b1, 4'd7,  8'h3C); step();
    drive(1'b0, 4'd0,  8'h00);
    repeat (30) step();

    // Overflow: seven consecutive requests into a depth-4 FIFO.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
      step();
    end
    drive(1'b0, 4'd0, 8'h00);
    chk("ovf_set0", o_ovf[0], 1);
    chk("ovf_set1", o_ovf[1], 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared0", o_ovf[0], 0);
    chk("ovf_cleared1", o_ovf[1], 0);
    repeat (60) step();

    // Variant timing: addr 9 / 0x5A, count strobe width on instance 1.
    drive(1'b1, 4'd9, 8'h5A); step();
    drive(1'b0, 4'd0, 8'h00);
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (o_sel[1] == 16'h0200) hits++;
    end
    chk("variant_strobe_width", hits, 3);

    // Reset in the middle of a strobe on instance 0.
    drive(1'b1, 4'd3, 8'hC3); step();
    drive(1'b1, 4'd1, 8'h77); step();
    drive(1'b1, 4'd2, 8'h99); step();
    drive(1'b0, 4'd0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_sel(0) == 16'h0008) found = 1'b1;
      else step();
    end
    chk("reach_strobe_ch3", found, 1);
    #3;
    CLR = 1'b1;
    #1;
    chk("async_sel0",  o_sel[0],  16'h0000);
    chk("async_data0", o_dout[0], 8'h00);
    chk("async_sel1",  o_sel[1],  16'h0000);
    chk("async_data1", o_dout[1], 8'h00);
    model_reset();
    #2;
    CLR = 1'b0;
    repeat (15) step();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 99) < 45, 4'($urandom_range(0, 15)), 8'($urandom));
      ovf_clr = ($urandom_range(0, 99) < 6);
      step();
    end
    drive(1'b0, 4'd0, 8'h00);
    ovf_clr = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
`default_nettype wire
